bridge_master_arbiter: RTL and testbench
========================================

# bridge_master_arbiter

Round-robin arbiter placed in front of the AHB slave port of the AHB-to-APB bridge so that up to NUM_MASTERS AHB masters can share it. Grants one master at a time and muxes its address/control and write data onto the bridge inputs. Tracks AHB address/data pipelining and enforces a per-tenure transfer quantum so that no requester starves.

## Interface
- NUM_MASTERS, 3: number of requesting masters (2..8).
- QUANTUM, 4: maximum accepted NONSEQ/SEQ transfers per tenure while another master is requesting.
- MIDX_W, $clog2(NUM_MASTERS): width of the master index.
- Hclk  in  1  clock; all state updates on the rising edge.
- Hreset  in  1  synchronous, active-high reset.
- Hbusreq  in  NUM_MASTERS  per-master bus request.
- Htrans_m  in  2*NUM_MASTERS  per-master Htrans; master i occupies bits [2i+1:2i].
- Hwrite_m  in  NUM_MASTERS  per-master Hwrite.
- Haddr_m  in  32*NUM_MASTERS  per-master Haddr.
- Hwdata_m  in  32*NUM_MASTERS  per-master Hwdata.
- Hreadyout  in  1  ready from the bridge.
- Hgrant  out  NUM_MASTERS  one-hot grant.
- Hmaster  out  MIDX_W  index of the address-phase owner.
- Htrans  out  2  muxed to the bridge.
- Hwrite  out  1  muxed to the bridge.
- Haddr  out  32  muxed to the bridge.
- Hwdata  out  32  muxed to the bridge, selected by the data-phase owner.
- Hreadyin  out  1  equals Hreadyout; driven to the bridge and to all masters.

## Operation
- Registers:
  - Hgrant (one-hot).
  - Hmaster.
  - dmaster (data-phase owner).
  - qcnt (0..QUANTUM-1).
- Address mux: Htrans, Hwrite and Haddr come from master Hmaster.
- Data mux: Hwdata comes from master dmaster.
- accept = Hreadyout & Htrans[1] (an NONSEQ or SEQ transfer from the current owner is taken this cycle).
- Arbitration is evaluated only in cycles with Hreadyout=1. A handover occurs when any of the following holds:
  - (a) Hbusreq[Hmaster]=0 and some other master requests.
  - (b) accept, qcnt=QUANTUM-1, and some other master requests.
- Winner: the first requesting master searching Hmaster+1, Hmaster+2, … modulo NUM_MASTERS. The current owner is considered last.
- No requests at all: the grant parks on master 0. Parking is a handover if Hmaster≠0.
- On handover:
  - Hgrant becomes onehot(winner).
  - Hmaster becomes winner.
  - qcnt becomes 0.
- Without handover: qcnt increments on accept, saturating at QUANTUM-1.
  - When it is at QUANTUM-1 with no competitor, it stays at QUANTUM-1.
  - The next accept then forces rotation as soon as any competitor appears.
- dmaster is loaded with Hmaster in every cycle with Hreadyout=1. Hreadyout=0 freezes dmaster, Hmaster, Hgrant and qcnt.
- A master losing grant mid-burst must restart with NONSEQ. The arbiter does not protect bursts.
- Hreset (synchronous) in any cycle, including mid-transfer:
  - Hgrant=1 (master 0).
  - Hmaster=0.
  - dmaster=0.
  - qcnt=0.
  - Outputs follow the master-0 mux.

## Timing
- Arbitration decision is combinational from Hbusreq, Htrans and Hreadyout. Grant and Hmaster register at the same edge, giving a 1-cycle grant latency.
- Newly granted master drives its address phase in the first cycle after Hgrant rises. Its data phase (Hwdata) is selected 1 cycle after its first address cycle with Hreadyout=1.
- Hreadyin = Hreadyout combinationally, with 0 latency.
- All mux outputs are combinational from registered selects; there is no extra pipeline stage.
- Reset values:
  - Hgrant=…001.
  - Hmaster=0.
  - Htrans, Hwrite, Haddr, Hwdata = master 0's inputs.

## Structure
- Shared package bridge_pkg holds:
  - HTRANS_IDLE=2'b00, HTRANS_BUSY=2'b01, HTRANS_NONSEQ=2'b10, HTRANS_SEQ=2'b11.
  - A function rr_next(req, last) returning the winner index.
- One natural sub-module, rr_select: purely combinational rotating priority encoder (req, last → winner, any). The top level holds the registers and muxes.
- Bridge top instantiates bridge_master_arbiter ahead of the existing slave/controller pair. The bridge Hreadyin is connected to this block's Hreadyin.

## Test plan
- Reset held 2 cycles with Hbusreq=3'b110 → Hgrant=3'b001, Hmaster=0 throughout. One cycle after release, Hgrant=3'b010.
- Master 1 alone issues 6 NONSEQ writes (Haddr 0x8000_0000+4k), Hreadyout=1 → grant never moves. Hwdata of transfer k is muxed from master 1 one cycle after its address.
- Masters 1 and 2 both request continuously, QUANTUM=4 → ownership rotates after every 4 accepts: 1,1,1,1,2,2,2,2,1….
- Hreadyout=0 for 3 cycles while master 2 requests and master 1 drops Hbusreq → Hgrant, Hmaster and dmaster are frozen. Handover to 2 occurs on the first Hreadyout=1 edge.
- All Hbusreq drop while master 2 owns → next edge Hgrant=3'b001, Hmaster=0. Bridge sees master 0's Htrans=IDLE.
- Hreset asserted mid-burst with Hmaster=2 and Hreadyout=0 → next edge Hgrant=001, Hmaster=0, dmaster=0, qcnt=0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared AHB bridge definitions: HTRANS encodings and the round-robin winner search.
package bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int unsigned RR_MAX   = 8;
    localparam int unsigned RR_IDX_W = 3;

    // First requester after 'last' (wrapping at n); 'last' itself has lowest priority.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_IDX_W-1:0] last,
        input int unsigned         n
    );
        logic [RR_IDX_W-1:0] win;
        int                  idx;
        win = '0;
        for (int k = int'(RR_MAX); k > 0; k--) begin
            if (k <= int'(n)) begin
                idx = (int'(last) + k) % int'(n);
                if (req[RR_IDX_W'(idx)]) begin
                    win = RR_IDX_W'(idx);
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational rotating-priority encoder: picks the next requester after 'last'.
module rr_select #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned MIDX_W      = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MIDX_W-1:0]      last,
    output logic [MIDX_W-1:0]      winner,
    output logic                   any
);
    import bridge_pkg::*;

    assign winner = MIDX_W'(rr_next(RR_MAX'(req), RR_IDX_W'(last), NUM_MASTERS));
    assign any    = |req;

endmodule

// File: rtl/bridge_master_arbiter.sv
// Round-robin multi-master front end for the AHB-to-APB bridge slave port,
// with address/data phase muxing and a per-tenure transfer quantum.
module bridge_master_arbiter #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned QUANTUM     = 4,
    parameter int unsigned MIDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      Hclk,
    input  logic                      Hreset,
    input  logic [NUM_MASTERS-1:0]    Hbusreq,
    input  logic [2*NUM_MASTERS-1:0]  Htrans_m,
    input  logic [NUM_MASTERS-1:0]    Hwrite_m,
    input  logic [32*NUM_MASTERS-1:0] Haddr_m,
    input  logic [32*NUM_MASTERS-1:0] Hwdata_m,
    input  logic                      Hreadyout,
    output logic [NUM_MASTERS-1:0]    Hgrant,
    output logic [MIDX_W-1:0]         Hmaster,
    output logic [1:0]                Htrans,
    output logic                      Hwrite,
    output logic [31:0]               Haddr,
    output logic [31:0]               Hwdata,
    output logic                      Hreadyin
);
    import bridge_pkg::*;

    localparam int unsigned QCNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    logic [MIDX_W-1:0]      dmaster;
    logic [QCNT_W-1:0]      qcnt;

    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [MIDX_W-1:0]      hmaster_nxt;
    logic [MIDX_W-1:0]      dmaster_nxt;
    logic [QCNT_W-1:0]      qcnt_nxt;

    logic [1:0]             trans_arr [NUM_MASTERS];
    logic                   write_arr [NUM_MASTERS];
    logic [31:0]            addr_arr  [NUM_MASTERS];
    logic [31:0]            wdata_arr [NUM_MASTERS];

    logic [MIDX_W-1:0]      winner;
    logic                   any_req;
    logic [NUM_MASTERS-1:0] own_mask;
    logic                   own_req;
    logic                   others_req;
    logic                   accept;
    logic                   qcnt_at_max;
    logic                   handover;
    logic [MIDX_W-1:0]      target;

    // Split the flat per-master buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            trans_arr[i] = Htrans_m[2*i +: 2];
            write_arr[i] = Hwrite_m[i];
            addr_arr[i]  = Haddr_m[32*i +: 32];
            wdata_arr[i] = Hwdata_m[32*i +: 32];
        end
    end

    assign Htrans   = trans_arr[Hmaster];
    assign Hwrite   = write_arr[Hmaster];
    assign Haddr    = addr_arr[Hmaster];
    assign Hwdata   = wdata_arr[dmaster];
    assign Hreadyin = Hreadyout;

    rr_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .MIDX_W      (MIDX_W)
    ) u_rr_select (
        .req    (Hbusreq),
        .last   (Hmaster),
        .winner (winner),
        .any    (any_req)
    );

    assign own_mask    = NUM_MASTERS'(1) << Hmaster;
    assign own_req     = |(Hbusreq & own_mask);
    assign others_req  = |(Hbusreq & ~own_mask);
    assign accept      = Hreadyout & Htrans[1];
    assign qcnt_at_max = (qcnt == QCNT_W'(QUANTUM - 1));

    // Handover decision; with no requests the grant parks on master 0.
    always_comb begin
        handover = 1'b0;
        target   = winner;
        if (!any_req) begin
            handover = (Hmaster != '0);
            target   = '0;
        end else begin
            handover = others_req & (~own_req | (accept & qcnt_at_max));
        end
    end

    always_comb begin
        grant_nxt   = Hgrant;
        hmaster_nxt = Hmaster;
        dmaster_nxt = dmaster;
        qcnt_nxt    = qcnt;
        if (Hreadyout) begin
            dmaster_nxt = Hmaster;
            if (handover) begin
                grant_nxt   = NUM_MASTERS'(1) << target;
                hmaster_nxt = target;
                qcnt_nxt    = '0;
            end else if (accept && !qcnt_at_max) begin
                qcnt_nxt = qcnt + QCNT_W'(1);
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            Hgrant  <= NUM_MASTERS'(1);
            Hmaster <= '0;
            dmaster <= '0;
            qcnt    <= '0;
        end else begin
            Hgrant  <= grant_nxt;
            Hmaster <= hmaster_nxt;
            dmaster <= dmaster_nxt;
            qcnt    <= qcnt_nxt;
        end
    end

endmodule

// File: tb/tb_bridge_master_arbiter.sv
// Directed bench for bridge_master_arbiter: reference model compared every cycle plus literal checks.
module tb_bridge_master_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned Q  = 4;
    localparam int unsigned MW = 2;

    logic              Hclk = 1'b0;
    logic              Hreset;
    logic [N-1:0]      Hbusreq;
    logic [2*N-1:0]    Htrans_m;
    logic [N-1:0]      Hwrite_m;
    logic [32*N-1:0]   Haddr_m;
    logic [32*N-1:0]   Hwdata_m;
    logic              Hreadyout;
    logic [N-1:0]      Hgrant;
    logic [MW-1:0]     Hmaster;
    logic [1:0]        Htrans;
    logic              Hwrite;
    logic [31:0]       Haddr;
    logic [31:0]       Hwdata;
    logic              Hreadyin;

    logic [1:0]        m_trans [N];
    logic              m_write [N];
    logic [31:0]       m_addr  [N];
    logic [31:0]       m_wdata [N];

    int checks = 0;
    int errors = 0;

    always #5 Hclk = ~Hclk;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            Htrans_m[2*i +: 2] = m_trans[i];
            Hwrite_m[i]        = m_write[i];
            Haddr_m[32*i +: 32]  = m_addr[i];
            Hwdata_m[32*i +: 32] = m_wdata[i];
        end
    end

    bridge_master_arbiter #(
        .NUM_MASTERS (N),
        .QUANTUM     (Q),
        .MIDX_W      (MW)
    ) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hbusreq   (Hbusreq),
        .Htrans_m  (Htrans_m),
        .Hwrite_m  (Hwrite_m),
        .Haddr_m   (Haddr_m),
        .Hwdata_m  (Hwdata_m),
        .Hreadyout (Hreadyout),
        .Hgrant    (Hgrant),
        .Hmaster   (Hmaster),
        .Htrans    (Htrans),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hreadyin  (Hreadyin)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner, data-phase owner and accepts taken in the current tenure.
    int  own    = 0;
    int  down   = 0;
    int  taken  = 0;
    bit  mvalid = 1'b0;
    bit  m_acc;
    bit  m_others;
    bit  m_hand;
    int  m_nxt;

    always @(posedge Hclk) begin
        if (Hreset) begin
            own = 0; down = 0; taken = 0; mvalid = 1'b1;
        end else if (mvalid && Hreadyout) begin
            m_acc    = m_trans[own][1];
            m_others = 1'b0;
            for (int j = 0; j < int'(N); j++)
                if (j != own && Hbusreq[j]) m_others = 1'b1;
            m_hand = 1'b0;
            m_nxt  = own;
            if (Hbusreq == '0) begin
                if (own != 0) begin m_hand = 1'b1; m_nxt = 0; end
            end else if (m_others && (!Hbusreq[own] || (m_acc && taken >= int'(Q) - 1))) begin
                m_hand = 1'b1;
                for (int k = int'(N) - 1; k >= 1; k--)
                    if (Hbusreq[(own + k) % int'(N)]) m_nxt = (own + k) % int'(N);
            end
            down = own;
            if (m_hand) begin own = m_nxt; taken = 0; end
            else if (m_acc) taken++;
        end
    end

    always @(negedge Hclk) begin
        if (mvalid) begin
            chk("model_hgrant",   32'(Hgrant),   32'(3'b001 << own));
            chk("model_hmaster",  32'(Hmaster),  32'(own));
            chk("model_htrans",   32'(Htrans),   32'(m_trans[own]));
            chk("model_hwrite",   32'(Hwrite),   32'(m_write[own]));
            chk("model_haddr",    Haddr,         m_addr[own]);
            chk("model_hwdata",   Hwdata,        m_wdata[down]);
            chk("model_hreadyin", 32'(Hreadyin), 32'(Hreadyout));
        end
    end

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    int rot_exp [9];
    int rst_exp [5];

    initial begin
        rot_exp = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        rst_exp = '{0, 0, 0, 0, 2};
        for (int i = 0; i < int'(N); i++) begin
            m_trans[i] = 2'b00;
            m_write[i] = 1'b0;
            m_addr[i]  = 32'(i + 1) << 28;
            m_wdata[i] = 32'hA000_0000 | 32'(i);
        end
        Hreset    = 1'b1;
        Hbusreq   = 3'b110;
        Hreadyout = 1'b1;

        // Reset held two cycles with masters 1 and 2 requesting.
        tick();
        chk("rst_grant_c1", 32'(Hgrant), 32'h1);
        chk("rst_master_c1", 32'(Hmaster), 32'h0);
        tick();
        chk("rst_grant_c2", 32'(Hgrant), 32'h1);
        Hreset = 1'b0;
        tick();
        chk("post_rst_grant", 32'(Hgrant), 32'h2);
        chk("post_rst_master", 32'(Hmaster), 32'h1);

        // Master 1 alone: six NONSEQ writes, data one cycle behind address.
        Hbusreq    = 3'b010;
        m_trans[1] = 2'b10;
        m_write[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            m_addr[1] = 32'h8000_0000 + 32'(4 * k);
            if (k > 0) m_wdata[1] = 32'hD000_0000 + 32'(k - 1);
            #2;
            chk("solo_grant", 32'(Hgrant), 32'h2);
            chk("solo_addr", Haddr, 32'h8000_0000 + 32'(4 * k));
            if (k > 0) chk("solo_wdata", Hwdata, 32'hD000_0000 + 32'(k - 1));
            tick();
        end
        m_trans[1] = 2'b00;
        m_wdata[1] = 32'hD000_0005;
        #2;
        chk("solo_last_wdata", Hwdata, 32'hD000_0005);
        chk("solo_last_grant", 32'(Hgrant), 32'h2);

        // Masters 1 and 2 contend from a fresh reset; quantum of four accepts.
        Hreset     = 1'b1;
        Hbusreq    = 3'b110;
        m_trans[1] = 2'b10;
        m_trans[2] = 2'b10;
        m_wdata[1] = 32'h1111_1111;
        m_wdata[2] = 32'h2222_2222;
        tick();
        Hreset = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("rotate_master", 32'(Hmaster), 32'(rot_exp[i]));
            tick();
        end

        // Stall: master 1 drops, master 2 waits, everything frozen.
        Hbusreq   = 3'b100;
        Hreadyout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_master", 32'(Hmaster), 32'h1);
            chk("stall_grant", 32'(Hgrant), 32'h2);
            chk("stall_wdata", Hwdata, 32'h1111_1111);
            chk("stall_readyin", 32'(Hreadyin), 32'h0);
            tick();
        end
        Hreadyout = 1'b1;
        tick();
        chk("unstall_master", 32'(Hmaster), 32'h2);
        chk("unstall_grant", 32'(Hgrant), 32'h4);

        // All requests drop: park on master 0, bridge sees IDLE.
        Hbusreq    = 3'b000;
        m_trans[0] = 2'b00;
        tick();
        chk("park_grant", 32'(Hgrant), 32'h1);
        chk("park_master", 32'(Hmaster), 32'h0);
        chk("park_htrans", 32'(Htrans), 32'h0);

        // Reset mid-burst while master 2 owns and the bridge stalls.
        Hbusreq = 3'b100;
        tick();
        chk("preburst_master", 32'(Hmaster), 32'h2);
        tick();
        Hreadyout = 1'b0;
        Hreset    = 1'b1;
        tick();
        chk("midrst_grant", 32'(Hgrant), 32'h1);
        chk("midrst_master", 32'(Hmaster), 32'h0);
        chk("midrst_wdata", Hwdata, 32'hA000_0000);
        Hreset     = 1'b0;
        Hreadyout  = 1'b1;

        // Master 0 owns with a cleared quantum count: four accepts before master 2.
        Hbusreq    = 3'b101;
        m_trans[0] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("requota_master", 32'(Hmaster), 32'(rst_exp[i]));
            tick();
        end
        Hbusreq = 3'b000;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
